// File: rtl/sd_emmc_dma_pkg.sv
// Definitions shared by the read- and write-direction SD/eMMC SDMA engines:
// FSM state encoding, default block size in words and SDMA buffer-boundary limits.
package sd_emmc_dma_pkg;

    localparam int BLK_WORDS_DEF = 128;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        FIFO_WR,
        BLK_CHECK,
        NEW_SYS_ADDR,
        XFER_DONE
    } dma_state_e;

    // Boundary limit in blocks, indexed by the 3-bit buffer boundary code (4 KiB .. 512 KiB).
    localparam logic [7:0][15:0] BND_LIMITS = {
        16'd1024, 16'd512, 16'd256, 16'd128, 16'd64, 16'd32, 16'd16, 16'd8
    };

endpackage

// File: rtl/sd_emmc_dma_boundary.sv
// SDMA buffer-boundary decode: turns the boundary code into a block limit and
// flags when the blocks moved since the last address load have reached it.
module sd_emmc_dma_boundary
    import sd_emmc_dma_pkg::*;
(
    input  logic [2:0]  buf_boundary,
    input  logic [15:0] bnd_count,
    output logic        bnd_hit
);

    logic [15:0] bnd_limit;

    // Purely combinational, so a new code takes effect on the very next compare.
    assign bnd_limit = BND_LIMITS[buf_boundary];
    assign bnd_hit   = (bnd_count == bnd_limit);

endmodule

// File: rtl/sd_emmc_controller_dma_rd.sv
// SDMA read engine: fetches host memory one AXI word at a time into the card-write FIFO.
// Define SD_DMA_RD_BOUNDARY_EN to enable the buffer-boundary stop and dma_int.
module sd_emmc_controller_dma_rd
    import sd_emmc_dma_pkg::*;
#(
    parameter int BLK_WORDS = BLK_WORDS_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] init_dma_sys_addr,
    input  logic [2:0]  buf_boundary,
    input  logic [15:0] block_count,
    input  logic        blk_count_ena,
    input  logic        sys_addr_changed,
    input  logic        dma_ena_trans_mode,
    input  logic        dir_dat_trans_mode,
    input  logic        dat_int_rst,
    input  logic        xfer_compl,
    output logic [31:0] read_addr,
    output logic        addr_read_valid,
    input  logic        addr_read_ready,
    input  logic [31:0] read_data,
    input  logic        data_read_valid,
    output logic        data_read_ready,
    output logic [31:0] fifo_wdata,
    output logic        fifo_we,
    input  logic        fifo_full,
    output logic        dma_int,
    output logic        data_int_cc
);

    dma_state_e  state, state_nxt;
    logic [15:0] word_cnt, blk_total, bnd_cnt;
    logic        bnd_hit, bnd_stop, last_word, cnt_done;
    logic        start, ar_set, ar_clr, capture, reload, cc_set, dma_set;

    sd_emmc_dma_boundary u_bnd (
        .buf_boundary (buf_boundary),
        .bnd_count    (bnd_cnt),
        .bnd_hit      (bnd_hit)
    );

    assign last_word       = (word_cnt == 16'(BLK_WORDS - 1));
    assign cnt_done        = blk_count_ena && (blk_total >= block_count);
    assign data_read_ready = (state == DATA);
    assign fifo_we         = (state == FIFO_WR);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        ar_set    = 1'b0;
        ar_clr    = 1'b0;
        capture   = 1'b0;
        reload    = 1'b0;
        cc_set    = 1'b0;
        dma_set   = 1'b0;
        case (state)
            IDLE:
                if (dma_ena_trans_mode && !dir_dat_trans_mode && !xfer_compl) begin
                    start     = 1'b1;
                    state_nxt = ADDR;
                end
            ADDR:
                // An issued AR is never abandoned; disable is only seen before valid rises.
                if (addr_read_valid) begin
                    if (addr_read_ready) begin
                        ar_clr    = 1'b1;
                        state_nxt = DATA;
                    end
                end else if (!dma_ena_trans_mode) begin
                    state_nxt = IDLE;
                end else if (!fifo_full) begin
                    ar_set = 1'b1;
                end
            DATA:
                if (data_read_valid) begin
                    capture   = 1'b1;
                    state_nxt = FIFO_WR;
                end
            FIFO_WR:
                if (last_word)                state_nxt = BLK_CHECK;
                else if (!dma_ena_trans_mode) state_nxt = IDLE;
                else                          state_nxt = ADDR;
            BLK_CHECK:
                if (cnt_done) begin
                    cc_set    = 1'b1;
                    state_nxt = XFER_DONE;
                end else if (bnd_stop) begin
                    dma_set   = 1'b1;
                    state_nxt = NEW_SYS_ADDR;
                end else begin
                    state_nxt = ADDR;
                end
            NEW_SYS_ADDR:
                if (!dma_ena_trans_mode) begin
                    state_nxt = IDLE;
                end else if (sys_addr_changed) begin
                    reload    = 1'b1;
                    state_nxt = ADDR;
                end
            XFER_DONE:
                if (xfer_compl) state_nxt = IDLE;
            default:
                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            read_addr       <= '0;
            addr_read_valid <= 1'b0;
            fifo_wdata      <= '0;
            word_cnt        <= '0;
            blk_total       <= '0;
            bnd_cnt         <= '0;
        end else begin
            if (start) begin
                read_addr <= init_dma_sys_addr;
                word_cnt  <= '0;
                blk_total <= '0;
                bnd_cnt   <= '0;
            end
            if (ar_set)      addr_read_valid <= 1'b1;
            else if (ar_clr) addr_read_valid <= 1'b0;
            if (capture) fifo_wdata <= read_data;
            if (fifo_we) begin
                read_addr <= read_addr + 32'd4;
                if (last_word) begin
                    word_cnt  <= '0;
                    blk_total <= (blk_total == 16'hFFFF) ? blk_total : blk_total + 16'd1;
                    bnd_cnt   <= bnd_cnt + 16'd1;
                end else begin
                    word_cnt  <= word_cnt + 16'd1;
                end
            end
            if (reload) begin
                read_addr <= init_dma_sys_addr;
                bnd_cnt   <= '0;
            end
        end
    end

    // Clear has priority so software never loses an acknowledge racing a new event.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           data_int_cc <= 1'b0;
        else if (dat_int_rst) data_int_cc <= 1'b0;
        else if (cc_set)      data_int_cc <= 1'b1;
    end

`ifdef SD_DMA_RD_BOUNDARY_EN
    assign bnd_stop = bnd_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)           dma_int <= 1'b0;
        else if (dat_int_rst) dma_int <= 1'b0;
        else if (dma_set)     dma_int <= 1'b1;
    end
`else
    logic unused_bnd;
    assign bnd_stop   = 1'b0;
    assign unused_bnd = bnd_hit ^ dma_set;
    assign dma_int    = 1'b0;
`endif

endmodule
